// File: rtl/ll_pkg.sv
// Shared widths and request encoding for the linked-list request path.
// The same package is used by linked_list_top.
package ll_pkg;

    localparam int PTR_WD     = 3;
    localparam int WR_DATA_WD = 8;
    localparam int RD_DATA_WD = WR_DATA_WD;

    typedef enum logic [2:0] {
        PUSH_HEAD,
        PUSH_TAIL,
        POP_HEAD_REQ,
        POP_TAIL_REQ,
        INSERT_AT,
        DELETE_AT
    } t_req_types;

    typedef struct packed {
        t_req_types              req_type;
        logic [PTR_WD-1:0]       pos;
        logic [WR_DATA_WD-1:0]   data;
    } t_req_entry;

endpackage

// File: rtl/ll_req_fifo.sv
// Synchronous FIFO with wrap-bit pointers; the head entry is read combinationally.
module ll_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    output logic [WIDTH-1:0]          pop_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Same index with differing wrap bits means every slot is occupied.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign count    = wr_ptr - rd_ptr;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ll_req_sequencer.sv
// Buffers producer requests and issues them one at a time to linked_list_top,
// forwarding each response (or a timeout abort) on a valid/ready port.
module ll_req_sequencer
    import ll_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_req_vld,
    output logic                    s_req_rdy,
    input  t_req_types              s_req_type,
    input  logic [PTR_WD-1:0]       s_req_pos,
    input  logic [WR_DATA_WD-1:0]   s_req_data,
    output logic                    req_vld,
    output t_req_types              req_type,
    output logic [PTR_WD-1:0]       req_pos,
    output logic [WR_DATA_WD-1:0]   req_data,
    input  logic                    intf_ready,
    input  logic                    resp_vld,
    input  logic                    resp_type,
    input  logic [RD_DATA_WD-1:0]   resp_data,
    input  logic                    resp_data_vld,
    output logic                    resp_taken,
    output logic                    m_resp_vld,
    input  logic                    m_resp_rdy,
    output logic                    m_resp_type,
    output logic [RD_DATA_WD-1:0]   m_resp_data,
    output logic                    m_resp_data_vld,
    output logic                    m_resp_err,
    output logic                    err_timeout,
    output logic                    busy
);

    localparam int AW   = $clog2(DEPTH);
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, ACK} t_seq_state;

    t_seq_state     state;
    logic [WD_W-1:0] wd_cnt;
    logic           rdy_q;
    t_req_entry     push_entry;
    t_req_entry     head_entry;
    logic           fifo_full;
    logic           fifo_empty;
    logic [AW:0]    fifo_count;
    logic           push;
    logic           pop;
    logic           drain;
    logic           out_free;

    // rdy_q keeps the producer port closed during reset and the first cycle after it.
    assign s_req_rdy  = rdy_q && !fifo_full;
    assign push       = s_req_vld && s_req_rdy;
    assign pop        = (state == IDLE) && !fifo_empty;
    assign drain      = m_resp_vld && m_resp_rdy;
    assign out_free   = !m_resp_vld || m_resp_rdy;
    assign busy       = (fifo_count != '0) || (state != IDLE);
    assign push_entry = '{req_type: s_req_type, pos: s_req_pos, data: s_req_data};

    ll_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(t_req_entry))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            rdy_q           <= 1'b0;
            wd_cnt          <= '0;
            req_vld         <= 1'b0;
            req_type        <= PUSH_HEAD;
            req_pos         <= '0;
            req_data        <= '0;
            resp_taken      <= 1'b0;
            m_resp_vld      <= 1'b0;
            m_resp_type     <= 1'b0;
            m_resp_data     <= '0;
            m_resp_data_vld <= 1'b0;
            m_resp_err      <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            rdy_q      <= 1'b1;
            resp_taken <= 1'b0;

            if (drain) begin
                m_resp_vld      <= 1'b0;
                m_resp_type     <= 1'b0;
                m_resp_data     <= '0;
                m_resp_data_vld <= 1'b0;
                m_resp_err      <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        req_vld  <= 1'b1;
                        req_type <= head_entry.req_type;
                        req_pos  <= head_entry.pos;
                        req_data <= head_entry.data;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (intf_ready) begin
                        req_vld <= 1'b0;
                        wd_cnt  <= '0;
                        state   <= WAIT_RESP;
                    end
                end
                // A pending response freezes the watchdog until the output slot frees up.
                WAIT_RESP: begin
                    if (resp_vld) begin
                        if (out_free) begin
                            m_resp_vld      <= 1'b1;
                            m_resp_type     <= resp_type;
                            m_resp_data     <= resp_data;
                            m_resp_data_vld <= resp_data_vld;
                            m_resp_err      <= 1'b0;
                            resp_taken      <= 1'b1;
                            state           <= ACK;
                        end
                    end else if (wd_cnt == WD_LAST) begin
                        if (out_free) begin
                            m_resp_vld      <= 1'b1;
                            m_resp_type     <= 1'b0;
                            m_resp_data     <= '0;
                            m_resp_data_vld <= 1'b0;
                            m_resp_err      <= 1'b1;
                            err_timeout     <= 1'b1;
                            state           <= IDLE;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ll_req_sequencer.sv
// Directed bench for ll_req_sequencer: a request/response queue model checked every
// cycle, a behavioural responder, and hand-computed spot checks.
module tb_ll_req_sequencer;
    import ll_pkg::*;

    localparam int TIMEOUT = 8;
    localparam logic [WR_DATA_WD-1:0] SILENT = 8'hEE;

    typedef struct packed {
        t_req_types              t;
        logic [PTR_WD-1:0]       p;
        logic [WR_DATA_WD-1:0]   d;
    } req_t;

    typedef struct packed {
        logic                    typ;
        logic [RD_DATA_WD-1:0]   d;
        logic                    dv;
        logic                    err;
    } resp_t;

    logic                  clk;
    logic                  reset;
    logic                  s_req_vld;
    logic                  s_req_rdy;
    t_req_types            s_req_type;
    logic [PTR_WD-1:0]     s_req_pos;
    logic [WR_DATA_WD-1:0] s_req_data;
    logic                  req_vld;
    t_req_types            req_type;
    logic [PTR_WD-1:0]     req_pos;
    logic [WR_DATA_WD-1:0] req_data;
    logic                  intf_ready;
    logic                  resp_vld;
    logic                  resp_type;
    logic [RD_DATA_WD-1:0] resp_data;
    logic                  resp_data_vld;
    logic                  resp_taken;
    logic                  m_resp_vld;
    logic                  m_resp_rdy;
    logic                  m_resp_type;
    logic [RD_DATA_WD-1:0] m_resp_data;
    logic                  m_resp_data_vld;
    logic                  m_resp_err;
    logic                  err_timeout;
    logic                  busy;

    int    n_pass = 0;
    int    n_checks = 0;
    int    fwd_cnt = 0;
    int    resp_delay = 0;
    int    fwd_mark;
    logic [RD_DATA_WD-1:0] last_fwd_data = '0;
    req_t  exp_req[$];
    resp_t exp_resp[$];

    logic  rsp_acc;
    logic  rsp_tk;
    logic  rsp_pending;
    int    rsp_cnt;
    req_t  rsp_seen;
    req_t  rsp_cur;

    ll_req_sequencer #(
        .DEPTH       (4),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .s_req_vld       (s_req_vld),
        .s_req_rdy       (s_req_rdy),
        .s_req_type      (s_req_type),
        .s_req_pos       (s_req_pos),
        .s_req_data      (s_req_data),
        .req_vld         (req_vld),
        .req_type        (req_type),
        .req_pos         (req_pos),
        .req_data        (req_data),
        .intf_ready      (intf_ready),
        .resp_vld        (resp_vld),
        .resp_type       (resp_type),
        .resp_data       (resp_data),
        .resp_data_vld   (resp_data_vld),
        .resp_taken      (resp_taken),
        .m_resp_vld      (m_resp_vld),
        .m_resp_rdy      (m_resp_rdy),
        .m_resp_type     (m_resp_type),
        .m_resp_data     (m_resp_data),
        .m_resp_data_vld (m_resp_data_vld),
        .m_resp_err      (m_resp_err),
        .err_timeout     (err_timeout),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Every accepted request yields exactly one forwarded response, in push order.
    task automatic modelPush(input req_t r);
        resp_t e;
        exp_req.push_back(r);
        if (r.d == SILENT) e = '{typ: 1'b0, d: '0, dv: 1'b0, err: 1'b1};
        else               e = '{typ: r.p[0], d: r.d ^ 8'h5A, dv: r.d[0], err: 1'b0};
        exp_resp.push_back(e);
    endtask

    task automatic applyStimulus(input t_req_types t, input logic [PTR_WD-1:0] p, input logic [WR_DATA_WD-1:0] d);
        int waited = 0;
        s_req_vld  = 1'b1;
        s_req_type = t;
        s_req_pos  = p;
        s_req_data = d;
        @(negedge clk);
        while (!s_req_rdy && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (s_req_rdy) modelPush('{t: t, p: p, d: d});
        else checkOutput("push_accept_timeout", 32'(s_req_rdy), 32'd1);
        @(posedge clk); #1;
        s_req_vld = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int limit);
        int n = 0;
        while ((exp_req.size() != 0 || exp_resp.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(exp_req.size() + exp_resp.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Responder standing in for linked_list_top: answers resp_delay cycles after acceptance, holds until taken.
    initial begin : responder
        resp_vld      = 1'b0;
        resp_type     = 1'b0;
        resp_data     = '0;
        resp_data_vld = 1'b0;
        rsp_pending   = 1'b0;
        rsp_cnt       = 0;
        rsp_cur       = '0;
        forever begin
            @(negedge clk);
            rsp_acc  = req_vld && intf_ready && !reset;
            rsp_tk   = resp_taken;
            rsp_seen = '{t: req_type, p: req_pos, d: req_data};
            @(posedge clk); #1;
            if (reset || rsp_tk) begin
                resp_vld      = 1'b0;
                resp_type     = 1'b0;
                resp_data     = '0;
                resp_data_vld = 1'b0;
            end
            if (reset) rsp_pending = 1'b0;
            if (rsp_acc) begin
                rsp_pending = (rsp_seen.d != SILENT);
                rsp_cnt     = resp_delay;
                rsp_cur     = rsp_seen;
            end
            if (rsp_pending) begin
                if (rsp_cnt == 0) begin
                    resp_vld      = 1'b1;
                    resp_type     = rsp_cur.p[0];
                    resp_data     = rsp_cur.d ^ 8'h5A;
                    resp_data_vld = rsp_cur.d[0];
                    rsp_pending   = 1'b0;
                end else begin
                    rsp_cnt--;
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (req_vld) begin
                    if (exp_req.size() == 0) checkOutput("req_spurious", 32'd1, 32'd0);
                    else begin
                        checkOutput("req_type", 32'(req_type), 32'(exp_req[0].t));
                        checkOutput("req_pos",  32'(req_pos),  32'(exp_req[0].p));
                        checkOutput("req_data", 32'(req_data), 32'(exp_req[0].d));
                        if (intf_ready) void'(exp_req.pop_front());
                    end
                end
                if (m_resp_vld) begin
                    if (exp_resp.size() == 0) checkOutput("m_resp_spurious", 32'd1, 32'd0);
                    else begin
                        checkOutput("m_resp_type", 32'(m_resp_type),     32'(exp_resp[0].typ));
                        checkOutput("m_resp_data", 32'(m_resp_data),     32'(exp_resp[0].d));
                        checkOutput("m_resp_dvld", 32'(m_resp_data_vld), 32'(exp_resp[0].dv));
                        checkOutput("m_resp_err",  32'(m_resp_err),      32'(exp_resp[0].err));
                        if (m_resp_rdy) begin
                            void'(exp_resp.pop_front());
                            fwd_cnt++;
                            last_fwd_data = m_resp_data;
                        end
                    end
                end
            end
        end
    end

    initial begin : global_guard
        #500000;
        $display("[TB] FAIL global_timeout: got stuck, expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin : main
        reset      = 1'b1;
        s_req_vld  = 1'b0;
        s_req_type = PUSH_HEAD;
        s_req_pos  = '0;
        s_req_data = '0;
        intf_ready = 1'b1;
        m_resp_rdy = 1'b1;

        @(negedge clk);
        checkOutput("rst_s_req_rdy",   32'(s_req_rdy),   32'd0);
        checkOutput("rst_req_vld",     32'(req_vld),     32'd0);
        checkOutput("rst_m_resp_vld",  32'(m_resp_vld),  32'd0);
        checkOutput("rst_resp_taken",  32'(resp_taken),  32'd0);
        checkOutput("rst_err_timeout", 32'(err_timeout), 32'd0);
        checkOutput("rst_busy",        32'(busy),        32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_rdy_first_cycle", 32'(s_req_rdy), 32'd0);
        @(negedge clk);
        checkOutput("rst_rdy_after",       32'(s_req_rdy), 32'd1);
        @(posedge clk); #1;

        $display("[TB] single request");
        resp_delay = 2;
        applyStimulus(PUSH_HEAD, 3'd0, 8'd5);
        @(negedge clk); checkOutput("single_req_vld_n1", 32'(req_vld), 32'd0);
        @(negedge clk); checkOutput("single_req_vld_n2", 32'(req_vld), 32'd1);
                        checkOutput("single_req_data",   32'(req_data), 32'd5);
        @(negedge clk); checkOutput("single_req_vld_n3", 32'(req_vld), 32'd0);
        waitNeg(2);     checkOutput("single_taken_early", 32'(resp_taken), 32'd0);
                        checkOutput("single_mvld_early",  32'(m_resp_vld), 32'd0);
        @(negedge clk); checkOutput("single_taken",      32'(resp_taken),  32'd1);
                        checkOutput("single_m_resp_vld", 32'(m_resp_vld),  32'd1);
                        checkOutput("single_m_resp_data", 32'(m_resp_data), 32'h5F);
                        checkOutput("single_m_resp_dvld", 32'(m_resp_data_vld), 32'd1);
                        checkOutput("single_m_resp_err", 32'(m_resp_err),  32'd0);
        @(negedge clk); checkOutput("single_taken_once", 32'(resp_taken),  32'd0);
                        checkOutput("single_busy_done",  32'(busy),        32'd0);
        @(posedge clk); #1;
        waitDrain("single_drain", 50);

        $display("[TB] fill and backpressure");
        resp_delay = 0;
        intf_ready = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(PUSH_TAIL, PTR_WD'(i), WR_DATA_WD'(i));
        s_req_vld  = 1'b1;
        s_req_data = 8'h77;
        @(negedge clk); checkOutput("fill_rdy_full",  32'(s_req_rdy), 32'd0);
                        checkOutput("fill_req_head",  32'(req_data),  32'd0);
                        checkOutput("fill_busy",      32'(busy),      32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); checkOutput("fill_rdy_held", 32'(s_req_rdy), 32'd0);
        end
        @(posedge clk); #1;
        s_req_vld  = 1'b0;
        intf_ready = 1'b1;
        fwd_mark = fwd_cnt;
        waitDrain("fill_drain", 300);
        checkOutput("fill_fwd_count", 32'(fwd_cnt - fwd_mark), 32'd5);
        checkOutput("fill_last_data", 32'(last_fwd_data),      32'h5E);

        $display("[TB] output stall");
        m_resp_rdy = 1'b0;
        applyStimulus(INSERT_AT, 3'd1, 8'h10);
        applyStimulus(DELETE_AT, 3'd2, 8'h11);
        waitNeg(20);
        checkOutput("stall_m_resp_vld",  32'(m_resp_vld),  32'd1);
        checkOutput("stall_m_resp_data", 32'(m_resp_data), 32'h4A);
        checkOutput("stall_no_taken",    32'(resp_taken),  32'd0);
        checkOutput("stall_no_timeout",  32'(err_timeout), 32'd0);
        checkOutput("stall_busy",        32'(busy),        32'd1);
        @(posedge clk); #1;
        m_resp_rdy = 1'b1;
        waitNeg(2);
        checkOutput("stall_second_taken", 32'(resp_taken),  32'd1);
        checkOutput("stall_second_data",  32'(m_resp_data), 32'h4B);
        @(posedge clk); #1;
        waitDrain("stall_drain", 50);

        $display("[TB] timeout");
        applyStimulus(POP_HEAD_REQ, 3'd4, SILENT);
        applyStimulus(POP_TAIL_REQ, 3'd5, 8'h21);
        waitNeg(9);
        checkOutput("to_not_yet_vld", 32'(m_resp_vld),  32'd0);
        checkOutput("to_not_yet_err", 32'(err_timeout), 32'd0);
        @(negedge clk);
        checkOutput("to_m_resp_vld", 32'(m_resp_vld),  32'd1);
        checkOutput("to_m_resp_err", 32'(m_resp_err),  32'd1);
        checkOutput("to_m_resp_data", 32'(m_resp_data), 32'd0);
        checkOutput("to_err_flag",   32'(err_timeout), 32'd1);
        @(negedge clk);
        checkOutput("to_next_req_vld",  32'(req_vld),  32'd1);
        checkOutput("to_next_req_data", 32'(req_data), 32'h21);
        @(posedge clk); #1;
        waitDrain("to_drain", 50);
        checkOutput("to_err_sticky", 32'(err_timeout), 32'd1);

        $display("[TB] reset mid-operation");
        applyStimulus(PUSH_HEAD, 3'd6, SILENT);
        applyStimulus(PUSH_TAIL, 3'd0, 8'h30);
        applyStimulus(PUSH_TAIL, 3'd1, 8'h31);
        applyStimulus(PUSH_TAIL, 3'd2, 8'h32);
        reset = 1'b1;
        exp_req.delete();
        exp_resp.delete();
        @(negedge clk); checkOutput("mid_busy_before", 32'(busy), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mid_busy",        32'(busy),        32'd0);
        checkOutput("mid_req_vld",     32'(req_vld),     32'd0);
        checkOutput("mid_m_resp_vld",  32'(m_resp_vld),  32'd0);
        checkOutput("mid_m_resp_err",  32'(m_resp_err),  32'd0);
        checkOutput("mid_err_timeout", 32'(err_timeout), 32'd0);
        checkOutput("mid_resp_taken",  32'(resp_taken),  32'd0);
        checkOutput("mid_s_req_rdy",   32'(s_req_rdy),   32'd0);
        @(negedge clk); checkOutput("mid_rdy_back", 32'(s_req_rdy), 32'd1);
        waitNeg(4);
        checkOutput("mid_fifo_flushed", 32'(busy),    32'd0);
        checkOutput("mid_no_issue",     32'(req_vld), 32'd0);
        @(posedge clk); #1;

        $display("[TB] wrap-around");
        resp_delay = 0;
        fwd_mark = fwd_cnt;
        for (int i = 0; i < 10; i++) applyStimulus(PUSH_TAIL, PTR_WD'(i), WR_DATA_WD'(i));
        waitDrain("wrap_drain", 300);
        checkOutput("wrap_fwd_count", 32'(fwd_cnt - fwd_mark), 32'd10);
        checkOutput("wrap_last_data", 32'(last_fwd_data),      32'h53);
        checkOutput("wrap_no_timeout", 32'(err_timeout),       32'd0);
        @(negedge clk); checkOutput("wrap_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
